// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - opcodes, sequencer select encodings and control-word type for seq_ctrl
package seq_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_CONT = 4'd0,
        OP_JMP  = 4'd1,
        OP_CJP  = 4'd2,
        OP_CJS  = 4'd3,
        OP_RTN  = 4'd4,
        OP_LDCT = 4'd5,
        OP_RPCT = 4'd6,
        OP_JZ   = 4'd7,
        OP_LDAR = 4'd8,
        OP_JAR  = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        SEL_PC  = 2'b00,
        SEL_AR  = 2'b01,
        SEL_STK = 2'b10,
        SEL_D   = 2'b11
    } sel_e;

    localparam logic [2:0] STK_DEPTH = 3'd4;

    // Control lines shared by all three sequencer slices; zero/re/fe are active-low.
    typedef struct packed {
        sel_e sel;
        logic zero;
        logic cin;
        logic re;
        logic fe;
        logic pup;
    } ctl_t;

    localparam ctl_t CTL_CONT  = '{sel: SEL_PC, zero: 1'b1, cin: 1'b1, re: 1'b1, fe: 1'b1, pup: 1'b0};
    localparam ctl_t CTL_HOLD  = '{sel: SEL_PC, zero: 1'b1, cin: 1'b0, re: 1'b1, fe: 1'b1, pup: 1'b0};
    localparam ctl_t CTL_RESET = '{sel: SEL_PC, zero: 1'b0, cin: 1'b0, re: 1'b1, fe: 1'b1, pup: 1'b0};

endpackage

// File: rtl/seq_ctrl_if.sv
// rtl/seq_ctrl_if.sv - microword/condition inputs and sequencer control outputs of seq_ctrl
interface seq_ctrl_if;
    logic [3:0]  op;
    logic [11:0] d_in;
    logic [3:0]  cc_in;
    logic [1:0]  csel;
    logic        pol;
    logic        hold;
    logic        s0;
    logic        s1;
    logic        zero;
    logic        cin;
    logic        re;
    logic        fe;
    logic        pup;
    logic        ctr_zero;
    logic [2:0]  depth;
    logic        stk_ovf;
    logic        stk_unf;

    modport master (
        output op, d_in, cc_in, csel, pol, hold,
        input  s0, s1, zero, cin, re, fe, pup, ctr_zero, depth, stk_ovf, stk_unf
    );

    modport slave (
        input  op, d_in, cc_in, csel, pol, hold,
        output s0, s1, zero, cin, re, fe, pup, ctr_zero, depth, stk_ovf, stk_unf
    );
endinterface

// File: rtl/seq_ctrl_stk_mon.sv
// rtl/seq_ctrl_stk_mon.sv - shadows the sequencer stack depth and latches over/underflow
module seq_ctrl_stk_mon
    import seq_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    output logic [2:0] depth,
    output logic       stk_ovf,
    output logic       stk_unf
);
    always_ff @(posedge clock) begin
        if (reset) begin
            depth   <= 3'd0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (push) begin
            if (depth == STK_DEPTH) stk_ovf <= 1'b1;
            else                    depth   <= depth + 3'd1;
        end else if (pop) begin
            if (depth == 3'd0) stk_unf <= 1'b1;
            else               depth   <= depth - 3'd1;
        end
    end
endmodule

// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - microprogram sequence controller driving three 4-bit sequencer slices
// Loop counter (LDCT/RPCT) is built only when SEQ_CTRL_LOOP_EN is defined.
module seq_ctrl
    import seq_ctrl_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    seq_ctrl_if.slave bus
);
    logic cond;
    logic push;
    logic pop;
    ctl_t ctl;
`ifdef SEQ_CTRL_LOOP_EN
    logic [11:0] counter;
    logic        ctr_load;
    logic        ctr_dec;
`endif

    assign cond = bus.cc_in[bus.csel] ^ bus.pol;

    always_comb begin
        ctl  = CTL_CONT;
        push = 1'b0;
        pop  = 1'b0;
`ifdef SEQ_CTRL_LOOP_EN
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
`endif
        if (reset) begin
            ctl = CTL_RESET;
        end else if (bus.hold) begin
            ctl = CTL_HOLD;
        end else begin
            case (bus.op)
                OP_JMP:  ctl.sel = SEL_D;
                OP_CJP:  if (cond) ctl.sel = SEL_D;
                OP_CJS:  if (cond) begin
                    ctl.sel = SEL_D;
                    ctl.fe  = 1'b0;
                    ctl.pup = 1'b1;
                    push    = 1'b1;
                end
                OP_RTN:  if (cond) begin
                    ctl.sel = SEL_STK;
                    ctl.fe  = 1'b0;
                    pop     = 1'b1;
                end
`ifdef SEQ_CTRL_LOOP_EN
                OP_LDCT: ctr_load = 1'b1;
                OP_RPCT: if (counter != 12'd0) begin
                    ctl.sel = SEL_D;
                    ctr_dec = 1'b1;
                end
`endif
                OP_JZ:   ctl.zero = 1'b0;
                OP_LDAR: ctl.re   = 1'b0;
                OP_JAR:  ctl.sel  = SEL_AR;
                default: ;
            endcase
        end
    end

`ifdef SEQ_CTRL_LOOP_EN
    always_ff @(posedge clock) begin
        if (reset)         counter <= 12'd0;
        else if (ctr_load) counter <= bus.d_in;
        else if (ctr_dec)  counter <= counter - 12'd1;
    end

    assign bus.ctr_zero = (counter == 12'd0);
`else
    logic unused_d_in;
    assign unused_d_in  = ^bus.d_in;
    assign bus.ctr_zero = 1'b1;
`endif

    assign bus.s1   = ctl.sel[1];
    assign bus.s0   = ctl.sel[0];
    assign bus.zero = ctl.zero;
    assign bus.cin  = ctl.cin;
    assign bus.re   = ctl.re;
    assign bus.fe   = ctl.fe;
    assign bus.pup  = ctl.pup;

    seq_ctrl_stk_mon u_stk_mon (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .depth   (bus.depth),
        .stk_ovf (bus.stk_ovf),
        .stk_unf (bus.stk_unf)
    );
endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - self-checking bench for seq_ctrl (vector table, directed sequences, random vs model)
module tb_seq_ctrl;
`ifdef SEQ_CTRL_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam logic [6:0] C_CONT  = 7'b00_11110;
    localparam logic [6:0] C_JMP   = 7'b11_11110;
    localparam logic [6:0] C_CALL  = 7'b11_11101;
    localparam logic [6:0] C_RET   = 7'b10_11100;
    localparam logic [6:0] C_JZ    = 7'b00_01110;
    localparam logic [6:0] C_LDAR  = 7'b00_11010;
    localparam logic [6:0] C_JAR   = 7'b01_11110;
    localparam logic [6:0] C_HOLD  = 7'b00_10110;
    localparam logic [6:0] C_RESET = 7'b00_00110;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    seq_ctrl_if bus();

    seq_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    int m_ctr   = 0;
    int m_depth = 0;
    bit m_ovf   = 1'b0;
    bit m_unf   = 1'b0;
    logic [6:0] last_ctl;

    typedef struct {
        logic [3:0]  op;
        logic [11:0] d;
        logic [3:0]  cc;
        logic [1:0]  cs;
        logic        pl;
        logic        hd;
        logic        rs;
        logic [6:0]  exp;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [6:0] model_ctl(input int op, input bit cond, input bit hd, input bit rs);
        logic [1:0] s = 2'b00;
        bit z = 1, ci = 1, r = 1, f = 1, p = 0;
        if (rs) begin
            z = 0; ci = 0;
        end else if (hd) begin
            ci = 0;
        end else begin
            if (op == 1 || (op == 2 && cond)) s = 2'b11;
            if (op == 3 && cond) begin s = 2'b11; f = 0; p = 1; end
            if (op == 4 && cond) begin s = 2'b10; f = 0; end
            if (op == 6 && LOOP_EN && m_ctr > 0) s = 2'b11;
            if (op == 7) z = 0;
            if (op == 8) r = 0;
            if (op == 9) s = 2'b01;
        end
        return {s, z, ci, r, f, p};
    endfunction

    function automatic void model_next(input int op, input int d, input bit cond, input bit hd, input bit rs);
        if (rs) begin
            m_ctr = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
        end else if (!hd) begin
            if (op == 3 && cond) begin
                if (m_depth == 4) m_ovf = 1; else m_depth++;
            end
            if (op == 4 && cond) begin
                if (m_depth == 0) m_unf = 1; else m_depth--;
            end
            if (op == 5 && LOOP_EN) m_ctr = d;
            if (op == 6 && LOOP_EN && m_ctr > 0) m_ctr--;
        end
    endfunction

    task automatic step(input logic [3:0] op, input logic [11:0] d, input logic [3:0] cc,
                        input logic [1:0] cs, input logic pl, input logic hd, input logic rs,
                        input string name);
        logic [3:0] ccv;
        bit cond;
        logic [5:0] exp_state;
        bus.op = op; bus.d_in = d; bus.cc_in = cc; bus.csel = cs; bus.pol = pl; bus.hold = hd;
        reset = rs;
        ccv  = cc;
        cond = ccv[cs] ^ pl;
        @(negedge clock);
        last_ctl  = {bus.s1, bus.s0, bus.zero, bus.cin, bus.re, bus.fe, bus.pup};
        exp_state = {(m_ctr == 0), 3'(m_depth), m_ovf, m_unf};
        check({name, "/ctl"}, 32'(last_ctl), 32'(model_ctl(int'(op), cond, hd, rs)));
        check({name, "/state"}, 32'({bus.ctr_zero, bus.depth, bus.stk_ovf, bus.stk_unf}), 32'(exp_state));
        model_next(int'(op), int'(d), cond, hd, rs);
        @(posedge clock);
        #1;
    endtask

    vec_t tbl[$];
    int   jumps;

    initial begin
        bus.op = 4'd1; bus.d_in = '0; bus.cc_in = '0; bus.csel = '0; bus.pol = 1'b0; bus.hold = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // reset dominates op and drives zero/cin low
        step(4'd1, 12'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, "rst_jmp");
        check("rst_zero_cin", 32'(last_ctl[4:3]), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_state", 32'({bus.ctr_zero, bus.depth, bus.stk_ovf, bus.stk_unf}), 32'b1_000_0_0);
        @(posedge clock);
        #1;

        tbl = '{
            '{4'd0, 12'h000, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, C_CONT,  "cont"},
            '{4'd1, 12'h123, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, C_JMP,   "jmp"},
            '{4'd2, 12'h000, 4'h2, 2'd1, 1'b0, 1'b0, 1'b0, C_JMP,   "cjp_t"},
            '{4'd2, 12'h000, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0, C_CONT,  "cjp_f"},
            '{4'd3, 12'h000, 4'h4, 2'd2, 1'b0, 1'b0, 1'b0, C_CALL,  "cjs_t"},
            '{4'd3, 12'h000, 4'h4, 2'd2, 1'b1, 1'b0, 1'b0, C_CONT,  "cjs_f"},
            '{4'd4, 12'h000, 4'h8, 2'd3, 1'b0, 1'b0, 1'b0, C_RET,   "rtn_t"},
            '{4'd4, 12'h000, 4'h8, 2'd3, 1'b1, 1'b0, 1'b0, C_CONT,  "rtn_f"},
            '{4'd5, 12'h000, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, C_CONT,  "ldct0"},
            '{4'd6, 12'h000, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, C_CONT,  "rpct0"},
            '{4'd7, 12'h000, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, C_JZ,    "jz"},
            '{4'd8, 12'h000, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, C_LDAR,  "ldar"},
            '{4'd9, 12'h000, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, C_JAR,   "jar"},
            '{4'd12,12'h000, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, C_CONT,  "op12"},
            '{4'd1, 12'h000, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0, C_HOLD,  "hold_jmp"},
            '{4'd3, 12'h000, 4'hF, 2'd0, 1'b0, 1'b1, 1'b0, C_HOLD,  "hold_cjs"},
            '{4'd9, 12'h000, 4'h0, 2'd0, 1'b0, 1'b1, 1'b1, C_RESET, "rst_hold"}
        };
        foreach (tbl[i]) begin
            step(tbl[i].op, tbl[i].d, tbl[i].cc, tbl[i].cs, tbl[i].pl, tbl[i].hd, tbl[i].rs, tbl[i].name);
            check({tbl[i].name, "/tbl"}, 32'(last_ctl), 32'(tbl[i].exp));
        end

        // conditional call pass/fail on depth
        step(4'd3, 12'h0, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0, "cjs_pass");
        step(4'd3, 12'h0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, "cjs_fail");
        check("cjs_depth", 32'(bus.depth), 32'd1);

        // loop: three taken RPCTs, then fall through
        step(4'd0, 12'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, "loop_rst");
        step(4'd5, 12'h003, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, "ldct3");
        jumps = 0;
        for (int k = 0; k < 5; k++) begin
            step(4'd6, 12'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, "rpct");
            if (last_ctl[6:5] == 2'b11) jumps++;
        end
        check("loop_jumps", 32'(jumps), LOOP_EN ? 32'd3 : 32'd0);
        check("loop_ctr_zero", 32'(bus.ctr_zero), 32'd1);

        // hold freezes the counter
        step(4'd5, 12'h005, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, "ldct5");
        for (int k = 0; k < 3; k++) begin
            step(4'd6, 12'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0, "hold_rpct");
            check("hold_rpct_ctl", 32'(last_ctl), 32'(C_HOLD));
        end
        jumps = 0;
        for (int k = 0; k < 7; k++) begin
            step(4'd6, 12'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, "rpct5");
            if (last_ctl[6:5] == 2'b11) jumps++;
        end
        check("hold_jumps", 32'(jumps), LOOP_EN ? 32'd5 : 32'd0);

        // stack overflow, then underflow after reset
        step(4'd0, 12'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, "stk_rst");
        for (int k = 0; k < 5; k++) step(4'd3, 12'h0, 4'h1, 2'd0, 1'b0, 1'b0, 1'b0, "cjs_fill");
        check("ovf_state", 32'({bus.depth, bus.stk_ovf, bus.stk_unf}), 32'b100_1_0);
        step(4'd3, 12'h0, 4'h1, 2'd0, 1'b0, 1'b0, 1'b1, "rst_midcall");
        step(4'd4, 12'h0, 4'h1, 2'd0, 1'b0, 1'b0, 1'b0, "rtn_empty");
        check("unf_state", 32'({bus.depth, bus.stk_ovf, bus.stk_unf}), 32'b000_0_1);

        // randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            step(4'($urandom_range(0, 15)), 12'($urandom_range(0, 6)), 4'($urandom),
                 2'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 40) == 0), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
